// File: rtl/sm_clk_ctrl_pkg.sv
// Shared state codes, default prescale and prescale mask helper for the
// debug run/step/burst clock controller.
package sm_clk_ctrl_pkg;

  typedef enum logic [1:0] {
    SM_CLKCTRL_HALT  = 2'd0,
    SM_CLKCTRL_RUN   = 2'd1,
    SM_CLKCTRL_BURST = 2'd2
  } sm_state_e;

  localparam int SM_CLKCTRL_SHIFT = 16;

  // Mask of the low (shift+devide) prescaler bits; all ones marks a tick.
  function automatic logic [31:0] pulse_mask(input int shift, input logic [3:0] devide);
    logic [5:0] sh;
    sh = 6'(shift) + {2'b00, devide};
    return (32'd1 << sh) - 32'd1;
  endfunction

endpackage

// File: rtl/sm_edge_detect.sv
// Rising-edge detector for already synchronised button/switch levels.
// History resets to 1 so that a level held through reset is not an edge.
module sm_edge_detect #(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] din,
  output logic [SIZE-1:0] rise
);

  logic [SIZE-1:0] hist_q;

  // Previous-cycle level of each input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist_q <= '1;
    else     hist_q <= din;
  end

  assign rise = din & ~hist_q;

endmodule

// File: rtl/sm_clk_ctrl.sv
// Debug run/step/burst controller producing a CPU clock-enable pulse stream.
//
// state | meaning
// HALT  | no pulses; accepts halt/step/burst/run edges
// RUN   | one pulse per prescale period until halt edge or breakpoint
// BURST | like RUN, but stops after the requested number of pulses
module sm_clk_ctrl
  import sm_clk_ctrl_pkg::*;
#(
  parameter int SHIFT = SM_CLKCTRL_SHIFT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  devide,
  input  logic        cmdRun,
  input  logic        cmdHalt,
  input  logic        cmdStep,
  input  logic        cmdBurst,
  input  logic [7:0]  burstLen,
  input  logic        bpEnable,
  input  logic [31:0] bpAddr,
  input  logic [31:0] pc,
  output logic        cpuEn,
  output logic [1:0]  state,
  output logic        bpHit,
  output logic [31:0] cycleCnt
);

  sm_state_e   state_q, state_d;
  logic [31:0] presc_q, presc_d;
  logic [7:0]  remain_q, remain_d;
  logic        en_q, en_d;
  logic        bp_q, bp_d;
  logic [31:0] cnt_q;

  logic [3:0]  cmd_rise;
  logic        halt_e, step_e, burst_e, run_e;
  logic [31:0] mask;
  logic        tick;
  logic        bp_match;

  sm_edge_detect #(.SIZE(4)) u_edge (
    .clk  (clk),
    .rst  (rst),
    .din  ({cmdHalt, cmdStep, cmdBurst, cmdRun}),
    .rise (cmd_rise)
  );

  assign {halt_e, step_e, burst_e, run_e} = cmd_rise;

  assign mask     = pulse_mask(SHIFT, devide);
  assign tick     = (presc_q & mask) == mask;
  assign bp_match = bpEnable && (pc == bpAddr);

  // State, prescaler, burst counter, pulse and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SM_CLKCTRL_HALT;
      presc_q  <= '0;
      remain_q <= '0;
      en_q     <= 1'b0;
      bp_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      remain_q <= remain_d;
      en_q     <= en_d;
      bp_q     <= bp_d;
      cnt_q    <= cnt_q + {31'd0, en_q};
    end
  end

  // Command acceptance, tick handling and breakpoint stop.
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    remain_d = remain_q;
    en_d     = 1'b0;
    bp_d     = bp_q;
    case (state_q)
      SM_CLKCTRL_RUN, SM_CLKCTRL_BURST: begin
        if (halt_e) begin
          state_d  = SM_CLKCTRL_HALT;
          presc_d  = '0;
          remain_d = '0;
        end else begin
          presc_d = presc_q + 32'd1;
          if (tick) begin
            if (bp_match) begin
              state_d  = SM_CLKCTRL_HALT;
              bp_d     = 1'b1;
              presc_d  = '0;
              remain_d = '0;
            end else begin
              en_d = 1'b1;
              if (state_q == SM_CLKCTRL_BURST) begin
                remain_d = remain_q - 8'd1;
                if (remain_q == 8'd1) begin
                  state_d = SM_CLKCTRL_HALT;
                  presc_d = '0;
                end
              end
            end
          end
        end
      end
      default: begin
        // HALT, and the unused encoding which falls back to HALT.
        state_d  = SM_CLKCTRL_HALT;
        presc_d  = '0;
        remain_d = '0;
        if (!halt_e) begin
          if (step_e) begin
            en_d = 1'b1;
            bp_d = 1'b0;
          end else if (burst_e) begin
            bp_d = 1'b0;
            if (burstLen != 8'd0) begin
              state_d  = SM_CLKCTRL_BURST;
              remain_d = burstLen;
            end
          end else if (run_e) begin
            bp_d    = 1'b0;
            state_d = SM_CLKCTRL_RUN;
          end
        end
      end
    endcase
  end

  assign cpuEn    = en_q;
  assign state    = state_q;
  assign bpHit    = bp_q;
  assign cycleCnt = cnt_q;

endmodule

// File: tb/tb_sm_clk_ctrl.sv
module tb_sm_clk_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  devide;
  logic        cmdRun, cmdHalt, cmdStep, cmdBurst;
  logic [7:0]  burstLen;
  logic        bpEnable;
  logic [31:0] bpAddr;
  logic [31:0] pc;
  logic        cpuEn;
  logic [1:0]  state;
  logic        bpHit;
  logic [31:0] cycleCnt;

  sm_clk_ctrl #(.SHIFT(0)) dut (
    .clk      (clk),
    .rst      (rst),
    .devide   (devide),
    .cmdRun   (cmdRun),
    .cmdHalt  (cmdHalt),
    .cmdStep  (cmdStep),
    .cmdBurst (cmdBurst),
    .burstLen (burstLen),
    .bpEnable (bpEnable),
    .bpAddr   (bpAddr),
    .pc       (pc),
    .cpuEn    (cpuEn),
    .state    (state),
    .bpHit    (bpHit),
    .cycleCnt (cycleCnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int pulses;

  // Reference model: mode 0 halt, 1 run, 2 burst; k counts cycles since start.
  int          m_mode;
  int unsigned m_k;
  int          m_rem;
  bit          m_en, m_bp;
  logic [31:0] m_cnt;
  bit          h_run, h_halt, h_step, h_burst;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_k = 0; m_rem = 0; m_en = 0; m_bp = 0; m_cnt = 0;
    h_run = 1; h_halt = 1; h_step = 1; h_burst = 1;
  endtask

  task automatic model_step();
    bit eh, es, eb, er, nen;
    int unsigned per;
    eh = cmdHalt && !h_halt;
    es = cmdStep && !h_step;
    eb = cmdBurst && !h_burst;
    er = cmdRun && !h_run;
    h_halt = cmdHalt; h_step = cmdStep; h_burst = cmdBurst; h_run = cmdRun;
    m_cnt = m_cnt + (m_en ? 32'd1 : 32'd0);
    nen = 0;
    per = 32'd1 << devide;
    if (m_mode != 0) begin
      if (eh) begin
        m_mode = 0; m_rem = 0;
      end else begin
        if ((m_k % per) == per - 1) begin
          if (bpEnable && pc == bpAddr) begin
            m_mode = 0; m_bp = 1; m_rem = 0;
          end else begin
            nen = 1;
            if (m_mode == 2) begin
              m_rem--;
              if (m_rem == 0) m_mode = 0;
            end
          end
        end
        m_k++;
      end
    end else if (!eh) begin
      if (es) begin
        nen = 1; m_bp = 0;
      end else if (eb) begin
        m_bp = 0;
        if (burstLen != 0) begin
          m_mode = 2; m_rem = burstLen; m_k = 0;
        end
      end else if (er) begin
        m_bp = 0; m_mode = 1; m_k = 0;
      end
    end
    m_en = nen;
  endtask

  task automatic cycle(input int n = 1);
    for (int i = 0; i < n; i++) begin
      model_step();
      @(posedge clk);
      #1;
      if (cpuEn) pulses++;
      chk("state", 32'(state), 32'(m_mode));
      chk("cpuEn", 32'(cpuEn), 32'(m_en));
      chk("bpHit", 32'(bpHit), 32'(m_bp));
      chk("cycleCnt", cycleCnt, m_cnt);
    end
  endtask

  // Asynchronous reset raised between edges; outputs must clear at once.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_cpuEn", 32'(cpuEn), 32'd0);
    chk("rst_bpHit", 32'(bpHit), 32'd0);
    chk("rst_cnt", cycleCnt, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    devide = 4'd0; cmdRun = 0; cmdHalt = 0; cmdStep = 0; cmdBurst = 0;
    burstLen = 8'd0; bpEnable = 0; bpAddr = 32'h10; pc = 32'h0;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Step edge at cycle 10.
    cycle(9);
    cmdStep = 1; pulses = 0; cycle(1);
    cmdStep = 0; cycle(4);
    chk("step_pulses", 32'(pulses), 32'd1);
    chk("step_cnt", cycleCnt, 32'd1);

    // Run with P=4, halt edge at t+9.
    devide = 4'd2; pulses = 0;
    cmdRun = 1; cycle(1);
    cmdRun = 0; cycle(8);
    cmdHalt = 1; cycle(1);
    chk("halt_state", 32'(state), 32'd0);
    cmdHalt = 0; cycle(6);
    chk("run_pulses", 32'(pulses), 32'd2);

    // Burst of 3 at P=1.
    devide = 4'd0; burstLen = 8'd3; pulses = 0;
    cmdBurst = 1; cycle(1);
    cmdBurst = 0; cycle(8);
    chk("burst3_pulses", 32'(pulses), 32'd3);

    // Zero-length burst, then 255.
    burstLen = 8'd0; pulses = 0;
    cmdBurst = 1; cycle(1);
    cmdBurst = 0; cycle(4);
    chk("burst0_pulses", 32'(pulses), 32'd0);
    burstLen = 8'd255; pulses = 0;
    cmdBurst = 1; cycle(1);
    cmdBurst = 0; cycle(270);
    chk("burst255_pulses", 32'(pulses), 32'd255);

    // Breakpoint stop, then step off it.
    devide = 4'd1; bpEnable = 1; bpAddr = 32'h10; pc = 32'h0;
    cmdRun = 1; cycle(1);
    cmdRun = 0; cycle(10);
    pc = 32'h10; cycle(3);
    pulses = 0; cycle(8);
    chk("bp_no_pulse", 32'(pulses), 32'd0);
    chk("bp_hit", 32'(bpHit), 32'd1);
    cmdStep = 1; cycle(1);
    cmdStep = 0; cycle(3);
    chk("bp_step_pulse", 32'(pulses), 32'd1);
    chk("bp_cleared", 32'(bpHit), 32'd0);
    bpEnable = 0;

    // Step and run edges together: step wins.
    pulses = 0;
    cmdStep = 1; cmdRun = 1; cycle(1);
    cmdStep = 0; cmdRun = 0; cycle(6);
    chk("steprun_pulses", 32'(pulses), 32'd1);
    chk("steprun_state", 32'(state), 32'd0);

    // Button held through reset.
    cmdRun = 1;
    do_reset();
    cycle(6);
    chk("held_state", 32'(state), 32'd0);
    cmdRun = 0; cycle(2);

    // Reset mid-burst.
    devide = 4'd0; burstLen = 8'd50;
    cmdBurst = 1; cycle(1);
    cmdBurst = 0; cycle(10);
    do_reset();
    cycle(3);

    // Random stimulus against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) cmdRun = ~cmdRun;
      if ($urandom_range(0, 23) == 0) cmdHalt = ~cmdHalt;
      if ($urandom_range(0, 15) == 0) cmdStep = ~cmdStep;
      if ($urandom_range(0, 15) == 0) cmdBurst = ~cmdBurst;
      if ($urandom_range(0, 63) == 0) devide = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) burstLen = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 99) == 0) bpEnable = ~bpEnable;
      if ($urandom_range(0, 7) == 0) pc = 32'($urandom_range(0, 4)) << 2;
      cycle(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
